// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an 8-entry FIFO, plus a consumer read gate.
// Latency: 1 cycle from request to strobe; writes stall while the occupancy mirror reads full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  rd_req,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_rd_en,
  output logic                  rd_err,
  output logic                  wr_stall,
  output logic [CNT_WIDTH-1:0]  occ,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE0 = 2'd1,
    WRITE1 = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] OCC_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] OCC_ONE  = CNT_WIDTH'(1);

  state_t state_q;
  logic   last_grant;  // 0: req0 won last, 1: req1 won last

  logic elig0, elig1, any_elig, full, empty, pick1, wr_go, rd_go;

  // A requester whose grant is on the outputs this cycle is masked, so a held
  // req is not granted twice for the same word.
  always_comb begin
    elig0    = req0 & ~gnt0;
    elig1    = req1 & ~gnt1;
    any_elig = elig0 | elig1;
    full     = (occ == OCC_FULL);
    empty    = (occ == '0);
    pick1    = elig1 & (~elig0 | ~last_grant);
    wr_go    = any_elig & ~full;
    rd_go    = rd_req & ~empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      fifo_rd_en <= 1'b0;
      rd_err     <= 1'b0;
      wr_stall   <= 1'b0;
      occ        <= '0;
    end else begin
      gnt0       <= wr_go & ~pick1;
      gnt1       <= wr_go & pick1;
      fifo_wr_en <= wr_go;
      wr_stall   <= any_elig & full;
      fifo_rd_en <= rd_go;
      rd_err     <= rd_req & empty;

      if (wr_go) begin
        fifo_din   <= pick1 ? din1 : din0;
        last_grant <= pick1;
      end

      // Occupancy is gated on registered occ, so a same-cycle read never frees
      // the slot a write is competing for.
      case ({wr_go, rd_go})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase

      if (wr_go)
        state_q <= pick1 ? WRITE1 : WRITE0;
      else if (any_elig)
        state_q <= STALL;
      else
        state_q <= IDLE;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: each task drives one scenario and checks
// the registered outputs 1 time unit after the rising edge.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, rd_req;
  logic [31:0] din0, din1;
  logic        gnt0, gnt1, fifo_wr_en, fifo_rd_en, rd_err, wr_stall;
  logic [31:0] fifo_din;
  logic [3:0]  occ;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // {gnt0, gnt1, wr_en, rd_en, rd_err, wr_stall, state[1:0], occ[3:0]}
  logic [11:0] obs;
  assign obs = {gnt0, gnt1, fifo_wr_en, fifo_rd_en, rd_err, wr_stall, state, occ};

  fifo_wr_arbiter #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1), .rd_req(rd_req),
    .gnt0(gnt0), .gnt1(gnt1), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_rd_en(fifo_rd_en), .rd_err(rd_err), .wr_stall(wr_stall),
    .occ(occ), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
    din0 = '0; din1 = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
    din0 = '0; din1 = '0;
    tick(); tick();
    checks++;
    if (obs !== 12'b000000_00_0000) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", obs, 12'b0);
    end
    checks++;
    if (fifo_din !== 32'h0) begin
      errors++; $display("FAIL reset_din: got %h expected %h", fifo_din, 32'h0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== 12'b000000_00_0000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", obs, 12'b0);
    end
  endtask

  task automatic test_single_write;
    do_reset();
    req0 = 1'b1; din0 = 32'hA5A5A5A5;
    tick();
    checks++;
    if (obs !== 12'b101000_01_0001) begin
      errors++; $display("FAIL single_grant: got %b expected %b", obs, 12'b101000_01_0001);
    end
    checks++;
    if (fifo_din !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL single_din: got %h expected %h", fifo_din, 32'hA5A5A5A5);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (obs !== 12'b000000_00_0001) begin
      errors++; $display("FAIL single_idle: got %b expected %b", obs, 12'b000000_00_0001);
    end
  endtask

  task automatic test_single_throughput;
    // req0 held alone: grants land every other cycle
    do_reset();
    req0 = 1'b1; din0 = 32'h0000_0007;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt0 !== ((i % 2) == 0)) begin
        errors++; $display("FAIL single_rate[%0d]: got %b expected %b", i, gnt0, ((i % 2) == 0));
      end
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (occ !== 4'd2) begin
      errors++; $display("FAIL single_rate_occ: got %0d expected %0d", occ, 2);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp;
    do_reset();
    req0 = 1'b1; din0 = 32'h11111111;
    req1 = 1'b1; din1 = 32'h22222222;
    for (int i = 0; i < 8; i++) begin
      tick();
      if ((i % 2) == 0) exp = {6'b101000, 2'd1, 4'(i + 1)};
      else              exp = {6'b011000, 2'd2, 4'(i + 1)};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL b2b_ctl[%0d]: got %b expected %b", i, obs, exp);
      end
      checks++;
      if (fifo_din !== (((i % 2) == 0) ? 32'h11111111 : 32'h22222222)) begin
        errors++; $display("FAIL b2b_din[%0d]: got %h", i, fifo_din);
      end
    end
    tick();
    checks++;
    if (obs !== 12'b000001_11_1000) begin
      errors++; $display("FAIL b2b_stall: got %b expected %b", obs, 12'b000001_11_1000);
    end
    tick();
    checks++;
    if (obs !== 12'b000001_11_1000) begin
      errors++; $display("FAIL b2b_stall_hold: got %b expected %b", obs, 12'b000001_11_1000);
    end
  endtask

  task automatic test_full_read;
    // continues from the full, stalled state left by test_back_to_back
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (obs !== 12'b000101_11_0111) begin
      errors++; $display("FAIL full_read: got %b expected %b", obs, 12'b000101_11_0111);
    end
    tick();
    checks++;
    if (obs !== 12'b101000_01_1000) begin
      errors++; $display("FAIL full_refill: got %b expected %b", obs, 12'b101000_01_1000);
    end
    checks++;
    if (fifo_din !== 32'h11111111) begin
      errors++; $display("FAIL full_refill_din: got %h expected %h", fifo_din, 32'h11111111);
    end
    tick();
    checks++;
    if (obs !== 12'b000001_11_1000) begin
      errors++; $display("FAIL full_restall: got %b expected %b", obs, 12'b000001_11_1000);
    end
  endtask

  task automatic test_reset_in_stall;
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 12'b000000_00_0000) begin
      errors++; $display("FAIL stall_reset: got %b expected %b", obs, 12'b0);
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b1; din1 = 32'h33333333;
    tick();
    checks++;
    if (obs !== 12'b011000_10_0001) begin
      errors++; $display("FAIL post_reset_gnt1: got %b expected %b", obs, 12'b011000_10_0001);
    end
    checks++;
    if (fifo_din !== 32'h33333333) begin
      errors++; $display("FAIL post_reset_din: got %h expected %h", fifo_din, 32'h33333333);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_read_empty;
    do_reset();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (obs !== 12'b000010_00_0000) begin
      errors++; $display("FAIL rd_err: got %b expected %b", obs, 12'b000010_00_0000);
    end
    tick();
    checks++;
    if (obs !== 12'b000000_00_0000) begin
      errors++; $display("FAIL rd_err_pulse: got %b expected %b", obs, 12'b0);
    end
  endtask

  task automatic test_rd_and_wr;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; din0 = 32'h44444444; din1 = 32'h55555555;
    tick(); tick(); tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 12'b000000_00_0011) begin
      errors++; $display("FAIL rdwr_setup: got %b expected %b", obs, 12'b000000_00_0011);
    end
    req1 = 1'b1; rd_req = 1'b1;
    tick();
    req1 = 1'b0; rd_req = 1'b0;
    checks++;
    if (obs !== 12'b011100_10_0011) begin
      errors++; $display("FAIL rdwr_both: got %b expected %b", obs, 12'b011100_10_0011);
    end
    checks++;
    if (fifo_din !== 32'h55555555) begin
      errors++; $display("FAIL rdwr_din: got %h expected %h", fifo_din, 32'h55555555);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_throughput();
    test_back_to_back();
    test_full_read();
    test_reset_in_stall();
    test_read_empty();
    test_rd_and_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of the 8-entry FIFO between two producers (req0/req1) using round-robin arbitration.
- Gates a single consumer's read requests against FIFO occupancy.
- Keeps its own occupancy count, which mirrors the FIFO, so that it never issues a write when full or a read when empty.
- Sits between the producers/consumer and the FIFO's wr_en/rd_en/din inputs. Flags rejected reads and stalled writes.

Parameters:
- DATA_WIDTH, 32, width of din0/din1/fifo_din
- DEPTH, 8, FIFO capacity in entries
- CNT_WIDTH, 4, width of occ; must hold 0..DEPTH

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  producer 0 write request; held until gnt0 is seen
- din0  input  DATA_WIDTH  producer 0 data; stable while req0 is high
- req1  input  1  producer 1 write request
- din1  input  DATA_WIDTH  producer 1 data
- rd_req  input  1  consumer read request; single-cycle pulse per word
- gnt0  output  1  pulse: the producer 0 word is issued this cycle
- gnt1  output  1  pulse: the producer 1 word is issued this cycle
- fifo_wr_en  output  1  write strobe to the FIFO
- fifo_din  output  DATA_WIDTH  write data to the FIFO
- fifo_rd_en  output  1  read strobe to the FIFO
- rd_err  output  1  pulse: rd_req was rejected because the FIFO was empty
- wr_stall  output  1  high while a request is pending and occ == DEPTH
- occ  output  CNT_WIDTH  occupancy mirror
- state  output  2  FSM state: IDLE=0, WRITE0=1, WRITE1=2, STALL=3

Behaviour:
- Reset values:
  - All outputs are 0 and state is IDLE.
  - Internal last_grant = 1, so req0 wins the first contest.
  - Reset has priority over all other activity, including mid-transfer.
  - Words granted before reset are not reissued.
- Registered outputs: every output is registered. A decision made from the inputs in cycle N appears on the outputs in cycle N+1, so latency from request to gnt/fifo_wr_en is 1 cycle.
- Eligibility:
  - req0 is eligible in cycle N if req0=1 and gnt0=0 in cycle N; likewise for req1. This masks re-grant of a word whose grant is still in flight.
  - A write can issue only if occ < DEPTH, evaluated on registered occ.
  - A read issued in the same cycle does not free a slot for a write.
- Arbitration:
  - One eligible requester: that requester wins.
  - Both eligible: the one that was not last_grant wins.
  - last_grant updates on every grant.
- Write issue:
  - The next cycle has fifo_wr_en=1, fifo_din = the winner's din, and gntX=1.
  - state goes to WRITE0 or WRITE1 according to the winner.
- Write blocked:
  - Condition: a requester is eligible and occ == DEPTH.
  - The next cycle has state=STALL, wr_stall=1, and fifo_wr_en=0.
  - STALL persists until occ < DEPTH. The first write then issues one cycle after occ drops.
- No eligible request and not stalled: state = IDLE, fifo_wr_en=0, gnt=0.
- Read path, evaluated in parallel with the write path:
  - rd_req with occ > 0: fifo_rd_en=1 the next cycle.
  - rd_req with occ == 0: rd_err=1 the next cycle, fifo_rd_en=0.
- Occupancy update:
  - Write only: occ+1. Read only: occ−1. Both: occ unchanged.
  - occ never exceeds DEPTH and never wraps below 0.
- A requester dropping req before being granted: its request is withdrawn without error.
- Throughput:
  - A single requester achieves at most one word every 2 cycles.
  - Two requesters alternate and achieve one word per cycle.

Test Plan:
- Reset, then req0=1 with din0=0xA5A5A5A5 held; drop req0 after gnt0 → gnt0 and fifo_wr_en high exactly 1 cycle later, fifo_din=0xA5A5A5A5, occ=1, state=WRITE0 then IDLE.
- req0 and req1 held continuously from occ=0 → grants alternate 0,1,0,1… one per cycle. After 8 writes: occ=8, state=STALL, wr_stall=1, fifo_wr_en=0.
- From occ=8 with both requests pending, pulse rd_req once → fifo_rd_en next cycle, occ=7, then a single write issues and occ returns to 8.
- Reset with occ=0, pulse rd_req → rd_err=1 for 1 cycle, fifo_rd_en=0, occ stays 0.
- occ=3 with rd_req and req1 in the same cycle → fifo_rd_en=1 and gnt1=1 together, occ=3.
- Assert reset during STALL with occ=8 → next cycle all outputs 0, state=IDLE. A subsequent req1-only request is granted after 1 cycle.
